// File: rtl/hsid_x_pkg.sv
// Shared constants and types for the HSID distance front end.
// Holds the upstream word / band sample widths and the unpacker FSM state type.
package hsid_x_pkg;

    localparam int unsigned HSID_WORD_WIDTH = 32;
    localparam int unsigned HSID_DATA_WIDTH = 16;

    typedef enum logic [0:0] {
        UNPACK_IDLE = 1'b0,
        UNPACK_RUN  = 1'b1
    } hsid_x_unpack_state_t;

endpackage

// File: rtl/hsid_x_word_fifo.sv
// Synchronous word FIFO with a synchronous flush input.
// Pointers carry one extra MSB so full and empty are told apart without a counter.
module hsid_x_word_fifo #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic [AW:0]      w_ptr_one;

    assign w_ptr_one = {{AW{1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + w_ptr_one;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + w_ptr_one;
            end
        end
    end

    // Storage is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = r_mem[r_rd_ptr[AW-1:0]];
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/hsid_x_word_unpack.sv
// Buffers upstream OBI read words and splits each into two band samples for the distance datapath.
// Optional macro HSID_X_UNPACK_ODD_PACK_EN packs odd-band pixels contiguously instead of word-aligning them.
module hsid_x_word_unpack
    import hsid_x_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = HSID_WORD_WIDTH,
    parameter int unsigned DATA_WIDTH  = HSID_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned BANDS_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   clear,
    input  logic [BANDS_WIDTH-1:0] bands,
    input  logic                   word_valid,
    input  logic [WORD_WIDTH-1:0]  word,
    output logic                   band_valid,
    output logic [DATA_WIDTH-1:0]  band_data,
    output logic                   band_last,
    input  logic                   band_ready,
    output logic                   fifo_full,
    output logic                   overflow,
    output logic                   idle
);

    hsid_x_unpack_state_t   r_state;
    logic [BANDS_WIDTH-1:0] r_bands;
    logic [BANDS_WIDTH-1:0] r_cnt;
    logic [WORD_WIDTH-1:0]  r_word;
    logic                   r_hs;
    logic                   r_reg_valid;
    logic                   r_overflow;

    logic                   w_run;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic [WORD_WIDTH-1:0]  w_fifo_rdata;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic                   w_hsk;
    logic                   w_last;
    logic                   w_final;
    logic [BANDS_WIDTH-1:0] w_one;
    logic [BANDS_WIDTH-1:0] w_last_idx;

    assign w_one      = {{(BANDS_WIDTH-1){1'b0}}, 1'b1};
    assign w_last_idx = r_bands - w_one;

    assign w_run  = (r_state == UNPACK_RUN) && !clear;
    assign w_hsk  = r_reg_valid && band_ready;
    assign w_last = r_reg_valid && (r_cnt == w_last_idx);

`ifdef HSID_X_UNPACK_ODD_PACK_EN
    assign w_final = r_hs;
`else
    // Odd pixels drop the upper half after their last band so the next pixel starts word-aligned.
    assign w_final = r_hs || (w_last && r_bands[0]);
`endif

    assign w_pop  = w_run && !w_fifo_empty && (!r_reg_valid || (w_hsk && w_final));
    assign w_push = w_run && word_valid && (!w_fifo_full || w_pop);
    assign w_drop = w_run && word_valid && w_fifo_full && !w_pop;

    hsid_x_word_fifo #(
        .WIDTH      (WORD_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (w_push),
        .wdata (word),
        .pop   (w_pop),
        .rdata (w_fifo_rdata),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= UNPACK_IDLE;
            r_bands     <= '0;
            r_cnt       <= '0;
            r_word      <= '0;
            r_hs        <= 1'b0;
            r_reg_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                UNPACK_IDLE: begin
                    if (start && (bands != '0)) begin
                        r_state <= UNPACK_RUN;
                        r_bands <= bands;
                    end
                end
                default: r_state <= UNPACK_RUN;
            endcase

            if (w_pop) begin
                r_word      <= w_fifo_rdata;
                r_hs        <= 1'b0;
                r_reg_valid <= 1'b1;
            end else if (w_hsk) begin
                if (w_final) begin
                    r_hs        <= 1'b0;
                    r_reg_valid <= 1'b0;
                end else begin
                    r_hs <= 1'b1;
                end
            end

            if (w_hsk) begin
                r_cnt <= w_last ? '0 : (r_cnt + w_one);
            end

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign band_valid = r_reg_valid;
    assign band_data  = r_hs ? r_word[WORD_WIDTH-1:DATA_WIDTH] : r_word[DATA_WIDTH-1:0];
    assign band_last  = w_last;
    assign fifo_full  = w_fifo_full;
    assign overflow   = r_overflow;
    assign idle       = (r_state == UNPACK_IDLE);

endmodule

// File: tb/tb_hsid_x_word_unpack.sv
// Scoreboard bench for hsid_x_word_unpack: directed scenarios plus randomized traffic.
// Expected bands come from a per-word model of the pixel/band rules; a negedge monitor compares.
`timescale 1ns/1ps
module tb_hsid_x_word_unpack;

    localparam int WW = 32;
    localparam int DW = 16;
    localparam int FD = 4;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [BW-1:0] bands = '0;
    logic          word_valid = 1'b0;
    logic [WW-1:0] word = '0;
    logic          band_ready = 1'b0;
    logic          band_valid;
    logic [DW-1:0] band_data;
    logic          band_last;
    logic          fifo_full;
    logic          overflow;
    logic          idle;

    always #5 clk = ~clk;

    hsid_x_word_unpack #(
        .WORD_WIDTH  (WW),
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (FD),
        .BANDS_WIDTH (BW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .clear      (clear),
        .bands      (bands),
        .word_valid (word_valid),
        .word       (word),
        .band_valid (band_valid),
        .band_data  (band_data),
        .band_last  (band_last),
        .band_ready (band_ready),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .idle       (idle)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic          wfinal;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   m_bands = 1;
    int   m_idx = 0;
    int   pushed_words = 0;
    int   consumed_words = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: each word yields its lower then upper half as consecutive bands of the current pixel.
    task automatic model_word(input logic [WW-1:0] w);
        exp_t e;
        bit   lo_last;
        lo_last  = (m_idx == m_bands - 1);
        e.data   = w[DW-1:0];
        e.last   = lo_last;
`ifdef HSID_X_UNPACK_ODD_PACK_EN
        e.wfinal = 1'b0;
`else
        e.wfinal = lo_last && ((m_bands % 2) == 1);
`endif
        exp_q.push_back(e);
        m_idx = lo_last ? 0 : m_idx + 1;
        if (!e.wfinal) begin
            e.data   = w[WW-1:DW];
            e.last   = (m_idx == m_bands - 1);
            e.wfinal = 1'b1;
            exp_q.push_back(e);
            m_idx = e.last ? 0 : m_idx + 1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [WW-1:0] w, input bit accept);
        word_valid = 1'b1;
        word       = w;
        if (accept) begin
            model_word(w);
            pushed_words++;
        end
        tick(1);
        word_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        exp_q.delete();
        pushed_words   = 0;
        consumed_words = 0;
    endtask

    task automatic do_start(input int b);
        start = 1'b1;
        bands = BW'(b);
        tick(1);
        start = 1'b0;
        if (b != 0) begin
            m_bands = b;
            m_idx   = 0;
        end
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 20; i++) begin
            if (band_valid) break;
            tick(1);
        end
        check("wait_valid", band_valid, 1);
    endtask

    task automatic drain();
        band_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        tick(2);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_band_valid", band_valid, 0);
    endtask

    // Monitor: compares each handshake against the scoreboard and checks hold-stability under stall.
    exp_t          mon_e;
    logic          mon_prev_stall = 1'b0;
    logic [DW-1:0] mon_prev_data = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst || clear) begin
                mon_prev_stall = 1'b0;
            end else begin
                if (mon_prev_stall) begin
                    check("stall_valid", band_valid, 1);
                    check("stall_data", band_data, mon_prev_data);
                end
                if (band_valid && band_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_band: got 0x%0h expected none", band_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("band_data", band_data, mon_e.data);
                        check("band_last", band_last, mon_e.last);
                        if (mon_e.wfinal) consumed_words++;
                    end
                end
                mon_prev_stall = band_valid && !band_ready;
                mon_prev_data  = band_data;
            end
        end
    end

    initial begin
        // Reset values
        tick(3);
        check("rst_band_valid", band_valid, 0);
        check("rst_band_data", band_data, 0);
        check("rst_band_last", band_last, 0);
        check("rst_fifo_full", fifo_full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_idle", idle, 1);
        rst = 1'b0;
        tick(1);

        // Basic unpack with latency
        do_start(4);
        check("run_idle", idle, 0);
        band_ready = 1'b1;
        drive_word(32'hBBBBAAAA, 1'b1);
        check("latency_edge_n", band_valid, 0);
        drive_word(32'hDDDDCCCC, 1'b1);
        check("latency_edge_n1_valid", band_valid, 1);
        check("latency_edge_n1_data", band_data, 16'hAAAA);
        drain();

        // Odd bands
        do_clear();
        do_start(3);
        band_ready = 1'b1;
        drive_word(32'h22221111, 1'b1);
        drive_word(32'h44443333, 1'b1);
        drive_word(32'h66665555, 1'b1);
        drain();

        // Backpressure mid-word
        do_clear();
        do_start(4);
        band_ready = 1'b0;
        drive_word(32'h87654321, 1'b1);
        drive_word(32'hCAFEF00D, 1'b1);
        wait_valid();
        band_ready = 1'b1;
        tick(1);
        band_ready = 1'b0;
        tick(5);
        check("bp_valid", band_valid, 1);
        check("bp_data", band_data, 16'h8765);
        drain();

        // Overflow with the unpack register already occupied
        do_clear();
        do_start(4);
        band_ready = 1'b0;
        drive_word(32'h0B0B0A0A, 1'b1);
        tick(2);
        check("ovf_reg_loaded", band_valid, 1);
        drive_word(32'h11112222, 1'b1);
        drive_word(32'h33334444, 1'b1);
        drive_word(32'h55556666, 1'b1);
        check("ovf_not_full_3", fifo_full, 0);
        drive_word(32'h77778888, 1'b1);
        check("ovf_full_4", fifo_full, 1);
        check("ovf_clear_4", overflow, 0);
        drive_word(32'h9999AAAA, 1'b0);
        check("ovf_set_5", overflow, 1);
        check("ovf_full_5", fifo_full, 1);
        drain();
        check("ovf_sticky", overflow, 1);
        do_clear();
        check("clr_overflow", overflow, 0);
        check("clr_idle", idle, 1);
        check("clr_fifo_full", fifo_full, 0);

        // Clear mid-pixel, then restart at band 0
        do_start(4);
        band_ready = 1'b0;
        drive_word(32'h00020001, 1'b1);
        drive_word(32'h00040003, 1'b1);
        wait_valid();
        band_ready = 1'b1;
        tick(2);
        band_ready = 1'b0;
        do_clear();
        check("midclr_idle", idle, 1);
        check("midclr_valid", band_valid, 0);
        check("midclr_overflow", overflow, 0);
        check("midclr_last", band_last, 0);
        do_start(4);
        band_ready = 1'b1;
        drive_word(32'h00BB00AA, 1'b1);
        drive_word(32'h00DD00CC, 1'b1);
        drain();

        // start with bands=0 is ignored and words are not accepted
        do_clear();
        do_start(0);
        check("b0_idle", idle, 1);
        band_ready = 1'b1;
        drive_word(32'h12345678, 1'b0);
        tick(3);
        check("b0_valid", band_valid, 0);
        check("b0_idle_after", idle, 1);
        check("b0_fifo_full", fifo_full, 0);

        // Randomized traffic, pushing only while the FIFO cannot be full
        for (int s = 0; s < 4; s++) begin
            do_clear();
            do_start(int'($urandom_range(1, 7)));
            for (int c = 0; c < 150; c++) begin
                band_ready = ($urandom_range(0, 3) != 0);
                if (($urandom_range(0, 1) == 1) && ((pushed_words - consumed_words) < FD)) begin
                    drive_word($urandom, 1'b1);
                end else begin
                    tick(1);
                end
            end
            drain();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
